// File: rtl/tcdm_pkg.sv
// Shared types and constants for the TCDM memory bank: grant FSM states,
// write-enable encoding and small sizing helpers.
package tcdm_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } tcdm_state_e;

    localparam logic WEN_WRITE = 1'b1;
    localparam logic WEN_READ  = 1'b0;

    // Index width for an array of the given depth; never narrower than one bit.
    function automatic int unsigned mem_addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned byte_lsb(input int unsigned strb_width);
        return (strb_width > 1) ? $clog2(strb_width) : 0;
    endfunction

endpackage

// File: rtl/tcdm_sram_be.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are not reset; only the read data register is.
module tcdm_sram_be
    import tcdm_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned StrbWidth = DataWidth / 8,
    parameter int unsigned Depth     = 256,
    parameter int unsigned AddrWidth = mem_addr_width(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic                 rd_zero_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [StrbWidth-1:0] be_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read data holds between reads; rd_zero_i substitutes 0 for accesses
    // that fall outside the array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tcdm_mem_bank.sv
// Single-port TCDM bank: grant FSM with optional wait cycles, address range
// check and byte-enable storage. Define TCDM_MEM_BANK_ERR_EN for err_o/err_cnt_o.
module tcdm_mem_bank
    import tcdm_pkg::*;
#(
    parameter int unsigned                 AXI_ADDR_WIDTH   = 32,
    parameter int unsigned                 AXI_DATA_WIDTH   = 32,
    parameter int unsigned                 AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8,
    parameter int unsigned                 DATA_MEM_LENGTH  = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0]   ADDR_BASE_OFFSET = '0,
    parameter int unsigned                 GNT_WAIT         = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    input  logic [AXI_ADDR_WIDTH-1:0] data_add_i,
    input  logic                      data_wen_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_wdata_i,
    input  logic [AXI_STRB_WIDTH-1:0] data_be_i,
    output logic                      data_gnt_o,
    output logic                      data_r_valid_o,
`ifdef TCDM_MEM_BANK_ERR_EN
    output logic [AXI_DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                      err_o,
    output logic [15:0]               err_cnt_o
`else
    output logic [AXI_DATA_WIDTH-1:0] data_r_rdata_o
`endif
);

    localparam int unsigned AddrLsb = byte_lsb(AXI_STRB_WIDTH);
    localparam int unsigned MemAw   = mem_addr_width(DATA_MEM_LENGTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] MemLen = AXI_ADDR_WIDTH'(DATA_MEM_LENGTH);
    localparam bit HasWait = (GNT_WAIT != 0);
    localparam logic [3:0] WaitLoad = HasWait ? 4'(GNT_WAIT - 1) : 4'd0;

    tcdm_state_e state_q;
    logic [3:0]  wait_cnt_q;
    logic        gnt;
    logic        xfer;
    logic        r_valid_q;

    logic [AXI_ADDR_WIDTH-1:0] addr_off;
    logic [AXI_ADDR_WIDTH-1:0] word_idx;
    logic                      in_range;

    // Below-base addresses wrap in the subtraction, so check them explicitly.
    assign addr_off = data_add_i - ADDR_BASE_OFFSET;
    assign word_idx = addr_off >> AddrLsb;
    assign in_range = (data_add_i >= ADDR_BASE_OFFSET) && (word_idx < MemLen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (data_req_i && HasWait) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WaitLoad;
                    end
                end
                WAIT: begin
                    if (!data_req_i || (wait_cnt_q == 4'd0)) begin
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is combinational so a zero-wait bank serves one access per cycle.
    always_comb begin
        gnt = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE:    gnt = data_req_i && !HasWait;
                WAIT:    gnt = data_req_i && (wait_cnt_q == 4'd0);
                default: gnt = 1'b0;
            endcase
        end
    end

    assign data_gnt_o = gnt;
    assign xfer       = data_req_i && gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= xfer && (data_wen_i == WEN_READ);
        end
    end

    assign data_r_valid_o = r_valid_q;

    tcdm_sram_be #(
        .DataWidth (AXI_DATA_WIDTH),
        .StrbWidth (AXI_STRB_WIDTH),
        .Depth     (DATA_MEM_LENGTH),
        .AddrWidth (MemAw)
    ) u_sram (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (xfer && (data_wen_i == WEN_WRITE) && in_range),
        .re_i      (xfer && (data_wen_i == WEN_READ)),
        .rd_zero_i (!in_range),
        .addr_i    (word_idx[MemAw-1:0]),
        .wdata_i   (data_wdata_i),
        .be_i      (data_be_i),
        .rdata_o   (data_r_rdata_o)
    );

`ifdef TCDM_MEM_BANK_ERR_EN
    logic        oor_xfer;
    logic        err_q;
    logic [15:0] err_cnt_q;

    assign oor_xfer = xfer && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= oor_xfer;
            if (oor_xfer && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_mem_bank.sv
// Directed bench for tcdm_mem_bank: a zero-wait bank and a GNT_WAIT=3 bank.
// Error port checks are compiled in when TCDM_MEM_BANK_ERR_EN is defined.
module tb_tcdm_mem_bank;
    import tcdm_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        req0, wen0, gnt0, rv0;
    logic [31:0] add0, wdata0, rdata0;
    logic [3:0]  be0;

    logic        req1, wen1, gnt1, rv1;
    logic [31:0] add1, wdata1, rdata1;
    logic [3:0]  be1;

`ifdef TCDM_MEM_BANK_ERR_EN
    logic        err0, err1;
    logic [15:0] err_cnt0, err_cnt1;
`endif

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tcdm_mem_bank #(
        .GNT_WAIT (0)
    ) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (req0),
        .data_add_i     (add0),
        .data_wen_i     (wen0),
        .data_wdata_i   (wdata0),
        .data_be_i      (be0),
        .data_gnt_o     (gnt0),
        .data_r_valid_o (rv0),
`ifdef TCDM_MEM_BANK_ERR_EN
        .data_r_rdata_o (rdata0),
        .err_o          (err0),
        .err_cnt_o      (err_cnt0)
`else
        .data_r_rdata_o (rdata0)
`endif
    );

    tcdm_mem_bank #(
        .GNT_WAIT (3)
    ) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (req1),
        .data_add_i     (add1),
        .data_wen_i     (wen1),
        .data_wdata_i   (wdata1),
        .data_be_i      (be1),
        .data_gnt_o     (gnt1),
        .data_r_valid_o (rv1),
`ifdef TCDM_MEM_BANK_ERR_EN
        .data_r_rdata_o (rdata1),
        .err_o          (err1),
        .err_cnt_o      (err_cnt1)
`else
        .data_r_rdata_o (rdata1)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        #1;
        vectors++;
        if (gnt0 !== 1'b0) begin
            miscompares++; $display("FAIL reset_gnt0: got %b want 0", gnt0);
        end
        vectors++;
        if (gnt1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_gnt1: got %b want 0", gnt1);
        end
        vectors++;
        if (rv0 !== 1'b0) begin
            miscompares++; $display("FAIL reset_rvalid: got %b want 0", rv0);
        end
        vectors++;
        if (rdata0 !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata0);
        end
`ifdef TCDM_MEM_BANK_ERR_EN
        vectors++;
        if (err0 !== 1'b0 || err_cnt0 !== 16'h0) begin
            miscompares++; $display("FAIL reset_err: got %b/%h want 0/0", err0, err_cnt0);
        end
`endif
        @(negedge clk);
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req0 = 1'b1; wen0 = WEN_WRITE; add0 = 32'h10; wdata0 = 32'hDEADBEEF; be0 = 4'hF;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL wr_gnt: got %b want 1", gnt0);
        end
        @(negedge clk);
        wen0 = WEN_READ; wdata0 = 32'h0;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL rd_gnt: got %b want 1", gnt0);
        end
        vectors++;
        if (rv0 !== 1'b0) begin
            miscompares++; $display("FAIL wr_no_rvalid: got %b want 0", rv0);
        end
        @(negedge clk);
        req0 = 1'b0;
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_data: got rv=%b %h want rv=1 deadbeef", rv0, rdata0);
        end
        @(negedge clk);
        vectors++;
        if (rv0 !== 1'b0 || rdata0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_hold: got rv=%b %h want rv=0 deadbeef", rv0, rdata0);
        end
    endtask

    task automatic test_byte_enable();
        @(negedge clk);
        req0 = 1'b1; wen0 = WEN_WRITE; add0 = 32'h14; wdata0 = 32'h11223344; be0 = 4'hF;
        @(negedge clk);
        wdata0 = 32'hAABBCCDD; be0 = 4'b0101;
        @(negedge clk);
        wen0 = WEN_READ; be0 = 4'hF;
        @(negedge clk);
        req0 = 1'b0;
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL be_merge: got rv=%b %h want rv=1 11bb33dd", rv0, rdata0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req0 = 1'b1; wen0 = WEN_WRITE; add0 = 32'h20; wdata0 = 32'h5; be0 = 4'hF;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL b2b_wr_gnt: got %b want 1", gnt0);
        end
        @(negedge clk);
        wen0 = WEN_READ;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL b2b_rd_gnt: got %b want 1", gnt0);
        end
        @(negedge clk);
        wen0 = WEN_WRITE; add0 = 32'h24; wdata0 = 32'h77;
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'h5) begin
            miscompares++; $display("FAIL b2b_raw: got rv=%b %h want rv=1 5", rv0, rdata0);
        end
        @(negedge clk);
        wen0 = WEN_READ;
        vectors++;
        if (rv0 !== 1'b0) begin
            miscompares++; $display("FAIL b2b_wr_no_rvalid: got %b want 0", rv0);
        end
        @(negedge clk);
        req0 = 1'b0;
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'h77) begin
            miscompares++; $display("FAIL b2b_alt: got rv=%b %h want rv=1 77", rv0, rdata0);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        req0 = 1'b1; wen0 = WEN_WRITE; add0 = 32'h0; wdata0 = 32'hCAFE0000; be0 = 4'hF;
        @(negedge clk);
        wen0 = WEN_READ; add0 = 32'h400;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL oor_rd_gnt: got %b want 1", gnt0);
        end
        @(negedge clk);
        wen0 = WEN_WRITE; wdata0 = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL oor_wr_gnt: got %b want 1", gnt0);
        end
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'h0) begin
            miscompares++; $display("FAIL oor_rd_zero: got rv=%b %h want rv=1 0", rv0, rdata0);
        end
`ifdef TCDM_MEM_BANK_ERR_EN
        vectors++;
        if (err0 !== 1'b1 || err_cnt0 !== 16'd1) begin
            miscompares++; $display("FAIL oor_rd_err: got %b/%0d want 1/1", err0, err_cnt0);
        end
`endif
        @(negedge clk);
        wen0 = WEN_READ; add0 = 32'h0;
        vectors++;
        if (rv0 !== 1'b0) begin
            miscompares++; $display("FAIL oor_wr_no_rvalid: got %b want 0", rv0);
        end
`ifdef TCDM_MEM_BANK_ERR_EN
        vectors++;
        if (err0 !== 1'b1 || err_cnt0 !== 16'd2) begin
            miscompares++; $display("FAIL oor_wr_err: got %b/%0d want 1/2", err0, err_cnt0);
        end
`endif
        @(negedge clk);
        req0 = 1'b0;
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'hCAFE0000) begin
            miscompares++;
            $display("FAIL oor_wr_discard: got rv=%b %h want rv=1 cafe0000", rv0, rdata0);
        end
`ifdef TCDM_MEM_BANK_ERR_EN
        vectors++;
        if (err0 !== 1'b0 || err_cnt0 !== 16'd2) begin
            miscompares++; $display("FAIL oor_err_pulse: got %b/%0d want 0/2", err0, err_cnt0);
        end
`endif
    endtask

    task automatic test_wait_states();
        logic exp;
        @(negedge clk);
        req1 = 1'b1; wen1 = WEN_WRITE; add1 = 32'h8; wdata1 = 32'h12345678; be1 = 4'hF;
        for (int c = 1; c <= 4; c++) begin
            #1;
            exp = (c == 4);
            vectors++;
            if (gnt1 !== exp) begin
                miscompares++; $display("FAIL wait_wr_gnt c%0d: got %b want %b", c, gnt1, exp);
            end
            @(negedge clk);
        end
        // Request stays high: the follow-on read pays the full wait again.
        wen1 = WEN_READ;
        for (int c = 1; c <= 4; c++) begin
            #1;
            exp = (c == 4);
            vectors++;
            if (gnt1 !== exp || rv1 !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_b2b_gnt c%0d: got gnt=%b rv=%b want gnt=%b rv=0",
                         c, gnt1, rv1, exp);
            end
            @(negedge clk);
        end
        req1 = 1'b0;
        vectors++;
        if (rv1 !== 1'b1 || rdata1 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wait_rd_data: got rv=%b %h want rv=1 12345678", rv1, rdata1);
        end
        @(negedge clk);
        req1 = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            #1;
            vectors++;
            if (gnt1 !== 1'b0) begin
                miscompares++; $display("FAIL wait_drop_gnt c%0d: got %b want 0", c, gnt1);
            end
            @(negedge clk);
        end
        req1 = 1'b0;
        #1;
        vectors++;
        if (gnt1 !== 1'b0) begin
            miscompares++; $display("FAIL wait_dropped_gnt: got %b want 0", gnt1);
        end
        @(negedge clk);
        req1 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            exp = (c == 4);
            vectors++;
            if (gnt1 !== exp || rv1 !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_retry_gnt c%0d: got gnt=%b rv=%b want gnt=%b rv=0",
                         c, gnt1, rv1, exp);
            end
            @(negedge clk);
        end
        req1 = 1'b0;
        vectors++;
        if (rv1 !== 1'b1 || rdata1 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wait_retry_data: got rv=%b %h want rv=1 12345678", rv1, rdata1);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req0 = 1'b1; wen0 = WEN_READ; add0 = 32'h10;
        #1;
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++; $display("FAIL rstrd_gnt: got %b want 1", gnt0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (gnt0 !== 1'b0) begin
            miscompares++; $display("FAIL rstrd_gnt_in_reset: got %b want 0", gnt0);
        end
        @(negedge clk);
        vectors++;
        if (rv0 !== 1'b0 || rdata0 !== 32'h0) begin
            miscompares++; $display("FAIL rstrd_during: got rv=%b %h want rv=0 0", rv0, rdata0);
        end
`ifdef TCDM_MEM_BANK_ERR_EN
        vectors++;
        if (err0 !== 1'b0 || err_cnt0 !== 16'h0) begin
            miscompares++; $display("FAIL rstrd_err: got %b/%h want 0/0", err0, err_cnt0);
        end
`endif
        req0  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rv0 !== 1'b0 || rdata0 !== 32'h0) begin
            miscompares++; $display("FAIL rstrd_after: got rv=%b %h want rv=0 0", rv0, rdata0);
        end
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        vectors++;
        if (rv0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rstrd_retained: got rv=%b %h want rv=1 deadbeef", rv0, rdata0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n  = 1'b0;
        req0   = 1'b0; wen0 = WEN_READ; add0 = '0; wdata0 = '0; be0 = '0;
        req1   = 1'b0; wen1 = WEN_READ; add1 = '0; wdata1 = '0; be1 = '0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_wait_states();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
